pipeline_ctrl: RTL

//  Central stall/flush controller for the 5-stage pipeline. Merges stall requests from IF/ID/EX/MEM into
//  the 6-bit stall vector consumed by pc_reg and every inter-stage register (if_id, id_ex, ex_mem, mem_wb).

---
 rtl/pipeline_ctrl_pkg.sv | 32 +++
 rtl/pipeline_ctrl_if.sv | 28 ++
 rtl/pipeline_ctrl_stall_watchdog.sv | 35 +++
 rtl/pipeline_ctrl.sv | 89 ++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared stall-bus constants, exception codes and controller states
package pipeline_ctrl_pkg;

  localparam int STALL_BUS_W = 6;

  localparam logic [STALL_BUS_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_BUS_W-1:0] STALL_IF   = 6'b000011;
  localparam logic [STALL_BUS_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_BUS_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_BUS_W-1:0] STALL_MEM  = 6'b011111;

  localparam logic [31:0] EXC_INT      = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL  = 32'h0000_0008;
  localparam logic [31:0] EXC_INVALID  = 32'h0000_000a;
  localparam logic [31:0] EXC_OVERFLOW = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP     = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET     = 32'h0000_000e;

  typedef enum logic [1:0] {
    CTRL_RUN      = 2'd0,
    CTRL_WAIT_BUS = 2'd1,
    CTRL_FLUSH    = 2'd2
  } ctrl_state_e;

  // ERET returns to the EPC; every other exception enters the common vector
  function automatic logic [31:0] exc_target(input logic [31:0] excepttype,
                                             input logic [31:0] epc,
                                             input logic [31:0] vector);
    return (excepttype == EXC_ERET) ? epc : vector;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - stall/exception bus between the pipeline stages and the controller
interface pipeline_ctrl_if;
  import pipeline_ctrl_pkg::*;

  logic                   stallreq_if;
  logic                   stallreq_id;
  logic                   stallreq_ex;
  logic                   stallreq_mem;
  logic                   exc_valid;
  logic [31:0]            excepttype;
  logic [31:0]            cp0_epc;
  logic [STALL_BUS_W-1:0] stall;
  logic                   flush;
  logic [31:0]            new_pc;

  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    output exc_valid, excepttype, cp0_epc,
    input  stall, flush, new_pc
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    input  exc_valid, excepttype, cp0_epc,
    output stall, flush, new_pc
  );

endinterface

// File: rtl/pipeline_ctrl_stall_watchdog.sv
// rtl/pipeline_ctrl_stall_watchdog.sv - total stall counter, stall-run counter and sticky timeout flag
module pipeline_ctrl_stall_watchdog #(
  parameter logic [15:0] STALL_TIMEOUT = 16'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stalled,
  output logic [31:0] o_stall_cnt,
  output logic        o_stall_timeout
);

  logic [31:0] r_stall_cnt;
  logic [15:0] r_run_cnt;
  logic        r_timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_run_cnt   <= '0;
      r_timeout   <= 1'b0;
    end else if (i_stalled) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
      if (r_run_cnt != 16'hFFFF)
        r_run_cnt <= r_run_cnt + 16'd1;
      if (r_run_cnt == STALL_TIMEOUT - 16'd1)
        r_timeout <= 1'b1;
    end else begin
      r_run_cnt <= '0;
    end
  end

  assign o_stall_cnt     = r_stall_cnt;
  assign o_stall_timeout = r_timeout;

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - pipeline stall merge, exception flush sequencing and stall watchdog
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
  parameter logic [15:0] STALL_TIMEOUT = 16'd1024
) (
  input  logic                clk,
  input  logic                rst,
  pipeline_ctrl_if.slave      ctrl,
  output logic [31:0]         o_stall_cnt,
  output logic                o_stall_timeout
);

  ctrl_state_e            r_state;
  ctrl_state_e            w_state_next;
  logic [31:0]            r_pend_type;
  logic [31:0]            w_pend_type_next;
  logic [STALL_BUS_W-1:0] w_stall;
  logic                   w_flush;
  logic [31:0]            w_new_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= CTRL_RUN;
      r_pend_type <= '0;
    end else begin
      r_state     <= w_state_next;
      r_pend_type <= w_pend_type_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_pend_type_next = r_pend_type;
    w_stall          = STALL_NONE;
    w_flush          = 1'b0;
    w_new_pc         = '0;
    if (!rst) begin
      case (r_state)
        CTRL_RUN: begin
          if (ctrl.exc_valid && !ctrl.stallreq_mem) begin
            w_flush  = 1'b1;
            w_new_pc = exc_target(ctrl.excepttype, ctrl.cp0_epc, EXC_VECTOR);
          end else if (ctrl.exc_valid) begin
            w_stall          = STALL_MEM;
            w_pend_type_next = ctrl.excepttype;
            w_state_next     = CTRL_WAIT_BUS;
          end else if (ctrl.stallreq_mem) begin
            w_stall = STALL_MEM;
          end else if (ctrl.stallreq_ex) begin
            w_stall = STALL_EX;
          end else if (ctrl.stallreq_id) begin
            w_stall = STALL_ID;
          end else if (ctrl.stallreq_if) begin
            w_stall = STALL_IF;
          end
        end
        // Upstream is frozen and the pending exception is the oldest, so new reports are ignored
        CTRL_WAIT_BUS: begin
          w_stall = STALL_MEM;
          if (!ctrl.stallreq_mem)
            w_state_next = CTRL_FLUSH;
        end
        CTRL_FLUSH: begin
          w_flush      = 1'b1;
          w_new_pc     = exc_target(r_pend_type, ctrl.cp0_epc, EXC_VECTOR);
          w_state_next = CTRL_RUN;
        end
        default: w_state_next = CTRL_RUN;
      endcase
    end
  end

  assign ctrl.stall  = w_stall;
  assign ctrl.flush  = w_flush;
  assign ctrl.new_pc = w_new_pc;

  pipeline_ctrl_stall_watchdog #(
    .STALL_TIMEOUT (STALL_TIMEOUT)
  ) u_stall_watchdog (
    .clk             (clk),
    .rst             (rst),
    .i_stalled       (|w_stall),
    .o_stall_cnt     (o_stall_cnt),
    .o_stall_timeout (o_stall_timeout)
  );

endmodule
